// File: rtl/alu_result_accumulator.sv
// alu_result_accumulator
//
// Reduction stage behind the execute-stage ALU adder/subtractor. Accepts a
// job of `length` signed WIDTH-bit ALU results and adds them into one
// two's-complement sum. It also keeps a sticky overflow flag and a sticky
// carry flag. The result is handed off through a valid/ready handshake.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   start      begin a job (sampled only while idle)
//   length     element count, latched when start is accepted (0 = empty job)
//   in_valid   in_s / in_v / in_cout carry a valid ALU result
//   in_ready   an element is accepted this cycle (high only while accumulating)
//   in_s       signed ALU result
//   in_v       ALU overflow flag for this element
//   in_cout    ALU carry-out for this element
//   out_valid  result available
//   out_ready  consumer takes the result
//   out_sum    accumulated sum
//   out_v      sticky overflow (element V or accumulation overflow)
//   out_c      sticky OR of accepted carry-outs
//   out_z      out_sum == 0
//   busy       a job is in progress or its result is waiting
//
// Build option:
//   ACC_SATURATE_EN  when defined, an accumulation overflow clamps the sum
//                    to the most positive or most negative value instead of
//                    wrapping. The sticky overflow flag is set either way.

module alu_result_accumulator #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_v,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_v,
    output logic             out_c,
    output logic             out_z,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e           stateQ;
    logic [WIDTH-1:0] accQ;
    logic [LEN_W-1:0] remainingQ;
    logic             stickyVQ;
    logic             stickyCQ;
    logic             inReadyQ;
    logic             outValidQ;
    logic             busyQ;

    logic [WIDTH-1:0] sumRaw;
    logic             accOvf;
    logic [WIDTH-1:0] accNext;
    logic             accept;

    // Overflow is only possible when both operands share a sign and the
    // raw sum leaves that sign.
    always_comb begin
        sumRaw  = accQ + in_s;
        accOvf  = (accQ[WIDTH-1] == in_s[WIDTH-1]) && (sumRaw[WIDTH-1] != accQ[WIDTH-1]);
        accNext = sumRaw;
`ifdef ACC_SATURATE_EN
        if (accOvf) begin
            // A non-negative accumulator can only overflow upwards.
            accNext = accQ[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    assign accept = in_valid & inReadyQ;

    // Single state machine; the handshake outputs are registered alongside
    // the state so they never depend on in_valid or out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ     <= StIdle;
            accQ       <= '0;
            remainingQ <= '0;
            stickyVQ   <= 1'b0;
            stickyCQ   <= 1'b0;
            inReadyQ   <= 1'b0;
            outValidQ  <= 1'b0;
            busyQ      <= 1'b0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (start) begin
                        accQ     <= '0;
                        stickyVQ <= 1'b0;
                        stickyCQ <= 1'b0;
                        busyQ    <= 1'b1;
                        if (length == '0) begin
                            stateQ     <= StDone;
                            remainingQ <= '0;
                            outValidQ  <= 1'b1;
                        end else begin
                            stateQ     <= StAccum;
                            remainingQ <= length;
                            inReadyQ   <= 1'b1;
                        end
                    end
                end

                StAccum: begin
                    if (accept) begin
                        accQ       <= accNext;
                        stickyVQ   <= stickyVQ | in_v | accOvf;
                        stickyCQ   <= stickyCQ | in_cout;
                        remainingQ <= remainingQ - LEN_W'(1);
                        if (remainingQ == LEN_W'(1)) begin
                            stateQ    <= StDone;
                            inReadyQ  <= 1'b0;
                            outValidQ <= 1'b1;
                        end
                    end
                end

                StDone: begin
                    if (out_ready) begin
                        stateQ    <= StIdle;
                        outValidQ <= 1'b0;
                        busyQ     <= 1'b0;
                    end
                end

                default: begin
                    stateQ    <= StIdle;
                    inReadyQ  <= 1'b0;
                    outValidQ <= 1'b0;
                    busyQ     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = outValidQ;
    assign busy      = busyQ;
    assign out_sum   = accQ;
    assign out_v     = stickyVQ;
    assign out_c     = stickyCQ;
    assign out_z     = (accQ == '0);

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Self-checking bench for alu_result_accumulator.
// A job-level reference model follows the DUT's inputs. A negedge compare
// process checks every output on every cycle. Directed jobs pin the model
// with literal expectations, and a randomized phase then exercises it
// further.

module tb_alu_result_accumulator;

    localparam int unsigned WIDTH = 19;
    localparam int unsigned LEN_W = 4;

    localparam longint Half = longint'(1) << (WIDTH - 1);
    localparam longint MaxV = Half - 1;
    localparam longint MinV = -Half;
    localparam longint Modulus = Half * 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] length = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_s = '0;
    logic             in_v = 1'b0;
    logic             in_cout = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_v;
    logic             out_c;
    logic             out_z;
    logic             busy;

    int errors = 0;
    int checks = 0;

    alu_result_accumulator #(
        .WIDTH(WIDTH),
        .LEN_W(LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .length   (length),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_s     (in_s),
        .in_v     (in_v),
        .in_cout  (in_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_v    (out_v),
        .out_c    (out_c),
        .out_z    (out_z),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic longint sx(input logic [WIDTH-1:0] v);
        return longint'($signed(v));
    endfunction

    // Exact integer sum, then brought back into range.
    function automatic bit sumOverflows(input longint a, input longint b);
        return (a + b > MaxV) || (a + b < MinV);
    endfunction

    function automatic longint sumNext(input longint a, input longint b);
        longint t;
        t = a + b;
`ifdef ACC_SATURATE_EN
        if (t > MaxV) return MaxV;
        if (t < MinV) return MinV;
`else
        if (t > MaxV) return t - Modulus;
        if (t < MinV) return t + Modulus;
`endif
        return t;
    endfunction

    // Reference model: 0 = idle, 1 = collecting elements, 2 = result waiting.
    int     mPhase = 0;
    int     mRem = 0;
    longint mAcc = 0;
    bit     mV = 1'b0;
    bit     mC = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase <= 0;
            mRem   <= 0;
            mAcc   <= 0;
            mV     <= 1'b0;
            mC     <= 1'b0;
        end else begin
            case (mPhase)
                0: if (start) begin
                    mAcc   <= 0;
                    mV     <= 1'b0;
                    mC     <= 1'b0;
                    mRem   <= int'(length);
                    mPhase <= (length == '0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    mAcc <= sumNext(mAcc, sx(in_s));
                    mV   <= mV | in_v | sumOverflows(mAcc, sx(in_s));
                    mC   <= mC | in_cout;
                    mRem <= mRem - 1;
                    if (mRem == 1) mPhase <= 2;
                end
                2: if (out_ready) mPhase <= 0;
                default: mPhase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", longint'(in_ready), longint'(mPhase == 1));
            chk("out_valid", longint'(out_valid), longint'(mPhase == 2));
            chk("busy", longint'(busy), longint'(mPhase != 0));
            chk("out_sum", sx(out_sum), mAcc);
            chk("out_v", longint'(out_v), longint'(mV));
            chk("out_c", longint'(out_c), longint'(mC));
            chk("out_z", longint'(out_z), longint'(mAcc == 0));
        end
    end

    task automatic startJob(input int len);
        @(negedge clk);
        start  = 1'b1;
        length = LEN_W'(len);
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Presents one element and returns on the edge that accepts it.
    task automatic sendElem(input longint s, input logic v, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_s     = WIDTH'(s);
        in_v     = v;
        in_cout  = c;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic consume(input int hold);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_in_ready"}, longint'(in_ready), 0);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_out_sum"}, sx(out_sum), 0);
        chk({tag, "_out_v"}, longint'(out_v), 0);
        chk({tag, "_out_c"}, longint'(out_c), 0);
        chk({tag, "_out_z"}, longint'(out_z), 1);
    endtask

    logic [WIDTH-1:0] heldSum;

    initial begin
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        // Plain sum, back-to-back elements.
        startJob(3);
        sendElem(5, 1'b0, 1'b0);
        sendElem(7, 1'b0, 1'b0);
        sendElem(-2, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sum_out_valid", longint'(out_valid), 1);
        chk("sum_value", sx(out_sum), 10);
        chk("sum_v", longint'(out_v), 0);
        chk("sum_z", longint'(out_z), 0);
        consume(0);

        // Accumulation overflow.
        startJob(2);
        sendElem(262143, 1'b0, 1'b0);
        sendElem(1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_v", longint'(out_v), 1);
`ifdef ACC_SATURATE_EN
        chk("ovf_sum", sx(out_sum), 262143);
`else
        chk("ovf_sum", sx(out_sum), -262144);
`endif
        consume(1);

        // Zero sum, then an empty job.
        startJob(2);
        sendElem(4, 1'b0, 1'b0);
        sendElem(-4, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("zero_sum", sx(out_sum), 0);
        chk("zero_z", longint'(out_z), 1);
        consume(0);
        startJob(0);
        chk("empty_out_valid", longint'(out_valid), 1);
        chk("empty_sum", sx(out_sum), 0);
        chk("empty_v", longint'(out_v), 0);
        chk("empty_c", longint'(out_c), 0);
        consume(0);

        // Gap in in_valid, sticky flags, back-pressure.
        startJob(4);
        sendElem(100, 1'b0, 1'b0);
        sendElem(-30, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        sendElem(50, 1'b0, 1'b1);
        sendElem(-7, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        heldSum = out_sum;
        chk("bp_sum", sx(out_sum), 113);
        chk("bp_v", longint'(out_v), 1);
        chk("bp_c", longint'(out_c), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", longint'(out_valid), 1);
            chk("bp_hold_sum", sx(out_sum), sx(heldSum));
        end
        consume(0);
        chk("bp_busy_drop", longint'(busy), 0);
        chk("bp_idle_hold", sx(out_sum), 113);

        // start during ACCUM and DONE, and in_valid during IDLE, are ignored.
        startJob(3);
        sendElem(1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        length   = LEN_W'(9);
        @(negedge clk);
        start = 1'b0;
        sendElem(2, 1'b0, 1'b0);
        sendElem(3, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ign_done", longint'(out_valid), 1);
        chk("ign_sum", sx(out_sum), 6);
        start  = 1'b1;
        length = '0;
        @(negedge clk);
        start = 1'b0;
        chk("ign_done_start", longint'(out_valid), 1);
        chk("ign_done_sum", sx(out_sum), 6);
        consume(0);
        in_valid = 1'b1;
        in_s     = WIDTH'(77);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ign_idle_busy", longint'(busy), 0);
        chk("ign_idle_sum", sx(out_sum), 6);

        // Asynchronous reset mid-job.
        startJob(5);
        sendElem(10, 1'b1, 1'b1);
        sendElem(20, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 checkResetOutputs("async_rst");
        #1 rst = 1'b0;
        startJob(1);
        sendElem(9, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_valid", longint'(out_valid), 1);
        chk("post_rst_sum", sx(out_sum), 9);
        consume(0);

        // Randomized traffic; the compare process checks every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 3) == 0);
            length    = LEN_W'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: in_s = WIDTH'(MaxV);
                1: in_s = WIDTH'(MinV);
                default: in_s = WIDTH'($urandom);
            endcase
            in_v      = ($urandom_range(0, 7) == 0);
            in_cout   = ($urandom_range(0, 3) == 0);
            out_ready = $urandom_range(0, 1) != 0;
        end
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
